// File: rtl/seq_penc_pkg.sv
// -----------------------------------------------------------------------------
// seq_penc_pkg
// Shared definitions for the sequential priority encoder:
//   - state_t      : FSM state encoding (IDLE, SCAN)
//   - DEFAULT_N    : default request-vector width (16)
//   - POP_MAX_W    : widest vector the popcount helper accepts
//   - pop_is_one() : true when exactly one bit of the argument is set
// -----------------------------------------------------------------------------
package seq_penc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEFAULT_N = 16;

    // Callers zero-extend their vector to this width, so N is limited to 64.
    localparam int POP_MAX_W = 64;

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
    function automatic logic pop_is_one(input logic [POP_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/pri_enc.sv
// -----------------------------------------------------------------------------
// pri_enc
// Combinational N-bit priority encoder.
//   vec : request vector, bit i requests index i
//   idx : index of the winning set bit (0 when vec is all-zero)
//   any : at least one bit of vec is set
// Direction: highest set index wins by default; with SEQ_PENC_LSB_FIRST_EN
// defined the lowest set index wins.
// -----------------------------------------------------------------------------
module pri_enc #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |vec;
`ifdef SEQ_PENC_LSB_FIRST_EN
        // Scan downward so the last hit, the lowest set index, wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`else
        // Scan upward so the last hit, the highest set index, wins.
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`endif
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// -----------------------------------------------------------------------------
// seq_priority_encoder
// Accepts an N-bit request vector and emits the index of every set bit, one
// index per accepted output beat, in priority order. All-zero vectors are
// consumed and flagged with a one-cycle zero_err pulse.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : producer presents a vector on in
//   in_ready   : block can capture a vector (IDLE only)
//   in         : request vector, bit i requests index i
//   out_valid  : out holds a valid index (SCAN only)
//   out_ready  : consumer accepts out this cycle
//   out        : highest-priority pending index
//   out_last   : out is the final index of the current vector
//   zero_err   : one-cycle pulse after an all-zero vector was accepted
//
// Configuration macro: SEQ_PENC_LSB_FIRST_EN selects lowest-index-first
// ordering (default is highest-index-first). Only the direction changes.
// -----------------------------------------------------------------------------
module seq_priority_encoder
    import seq_penc_pkg::*;
#(
    parameter  int N     = DEFAULT_N,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_last,
    output logic             zero_err
);

    state_t         state_q,     state_d;
    logic [N-1:0]   pend_q,      pend_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q,  in_ready_d;
    logic           zero_err_q,  zero_err_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             last_beat;
    logic [N-1:0]     clr_mask;

    pri_enc #(.N(N)) u_pri_enc (
        .vec (pend_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // pend is cleared on the final handshake, so in IDLE the encoder sees
    // zero and out/out_last read 0 without extra gating.
    assign last_beat = enc_any & pop_is_one(POP_MAX_W'(pend_q));

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        zero_err_d  = 1'b0;
        clr_mask    = '0;
        clr_mask[enc_idx] = 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (|in) begin
                        pend_d  = in;
                        state_d = SCAN;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_d = pend_q & ~clr_mask;
                    if (last_beat) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase

        // Handshake flags are registered copies of the next state, so neither
        // out_ready nor in_valid reaches any output combinationally.
        out_valid_d = (state_d == SCAN);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            zero_err_q  <= zero_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = enc_idx;
    assign out_last  = last_beat;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
module tb_seq_priority_encoder;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out;
    logic          out_last;
    logic          zero_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    seq_priority_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .zero_err  (zero_err)
    );

    always #5 clk = ~clk;

    // Inputs are changed and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list of set-bit indices in the order the consumer must see them.
    task automatic expected_order(input logic [N-1:0] v, output int q[$]);
        q = {};
`ifdef SEQ_PENC_LSB_FIRST_EN
        for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
`else
        for (int i = N - 1; i >= 0; i--) if (v[i]) q.push_back(i);
`endif
    endtask

    // Present v for one accepted cycle, waiting (bounded) for in_ready.
    task automatic send(input logic [N-1:0] v);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("in_ready_before_send", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = N'($urandom);
    endtask

    // Consume all beats of v; stall_pct is the chance of holding out_ready low.
    task automatic drain(input logic [N-1:0] v, input int stall_pct);
        int q[$];
        expected_order(v, q);
        for (int k = 0; k < q.size(); k++) begin
            int stalls = 0;
            forever begin
                out_ready = ($urandom_range(99) >= stall_pct) || (stalls >= 4);
                check("beat_valid", out_valid, 1);
                check("beat_index", out, q[k]);
                check("beat_last", out_last, (k == q.size() - 1));
                check("beat_in_ready_low", in_ready, 0);
                tick();
                if (out_ready) break;
                stalls++;
            end
        end
        out_ready = 1'b0;
        check("after_last_valid_low", out_valid, 0);
        check("after_last_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [N-1:0] v;
        int q[$];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out", out, 0);
        check("reset_out_last", out_last, 0);
        check("reset_zero_err", zero_err, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", in_ready, 1);

        // Reset in the middle of a scan.
        send(16'hF000);
        expected_order(16'hF000, q);
        out_ready = 1'b1;
        check("rst_scan_b0", out, q[0]);
        tick();
        check("rst_scan_b1", out, q[1]);
        tick();
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out", out, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_zero_err", zero_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_in_ready", in_ready, 1);
        check("rst_release_out_valid", out_valid, 0);
        send(16'h0001);
        drain(16'h0001, 0);

        // Sparse vector at full throughput.
        send(16'h8421);
        drain(16'h8421, 0);

        // All-zero vector.
        send(16'h0000);
        check("zero_err_pulse", zero_err, 1);
        check("zero_no_valid", out_valid, 0);
        check("zero_in_ready", in_ready, 1);
        tick();
        check("zero_err_cleared", zero_err, 0);
        check("zero_no_valid_2", out_valid, 0);

        // Back-pressure: index held stable while out_ready is low.
        send(16'h00C0);
        expected_order(16'h00C0, q);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_index", out, q[0]);
            check("stall_last", out_last, 0);
            tick();
        end
        drain(16'h00C0, 0);

        // All bits set.
        send(16'hFFFF);
        drain(16'hFFFF, 0);

        // Second vector held on in during SCAN must wait for in_ready.
        send(16'h0183);
        in_valid = 1'b1;
        in_data  = 16'h4200;
        drain(16'h0183, 30);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        drain(16'h4200, 30);

        // Random vectors with random back-pressure.
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(3))
                0:       v = N'(1) << $urandom_range(N - 1);
                1:       v = '0;
                default: v = N'($urandom);
            endcase
            send(v);
            if (v == '0) begin
                check("rand_zero_err", zero_err, 1);
                check("rand_zero_no_valid", out_valid, 0);
                tick();
                check("rand_zero_err_clear", zero_err, 0);
            end else begin
                drain(v, 40);
            end
            for (int g = $urandom_range(2); g > 0; g--) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_priority_encoder.md
# seq_priority_encoder

Parametrised sequential priority encoder, the successor to the 16-to-4 combinational encoder. It accepts an N-bit request vector with any number of bits set, and emits the index of every set bit, one index per accepted output beat, in priority order. It sits between request producers (interrupt and arbiter front-ends) and single-index consumers, with valid/ready handshakes on both sides. It also flags all-zero vectors instead of producing an undefined code.

## Interface
- N, 16, request vector width; N ≥ 2.
- IDX_W, $clog2(N), index width; for N=16 this is 4. Derived; do not override.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a vector on `in`.
- in_ready  output  1  block can capture a vector (IDLE only).
- in  input  N  request vector; bit i requests index i.
- out_valid  output  1  `out` holds a valid index.
- out_ready  input  1  consumer accepts `out` this cycle.
- out  output  IDX_W  index of the current highest-priority pending bit.
- out_last  output  1  current index is the final one for this vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

## Operation
- State machine with two states:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- In IDLE, when in_valid is high:
  - Nonzero `in`: capture it into the `pend` register, then go to SCAN.
  - All-zero `in`: consume it, stay in IDLE, and pulse zero_err on the next cycle. No output beat is produced.
- In SCAN:
  - `out` is the priority-encoded index of `pend`. Default priority is highest index first.
  - out_last = 1 when popcount(pend) == 1.
  - On out_valid && out_ready: clear bit `out` in `pend`. If out_last is high, go to IDLE; otherwise stay in SCAN.
  - When out_ready is low, `out`, out_last and `pend` hold stable. out_valid never drops without a handshake.
- A vector with P set bits produces exactly P beats, each index distinct, ending with exactly one out_last beat.
- `out` is a function of `pend` only; there is no combinational path from in or in_valid to any output.
- The out_ready → in_ready path goes through state only, so there is no combinational path there either.
- In IDLE, `out` and out_last are 0.

## Timing
- Reset values (asynchronous): state=IDLE, pend=0, out_valid=0, out=0, out_last=0, zero_err=0, in_ready=1. in_ready is 1 on the first cycle after rst deasserts.
- Capture at edge k → out_valid=1 after edge k; first index visible in cycle k+1. Latency is 1 cycle.
- With out_ready held high, throughput is one index per cycle, so a vector occupies P cycles in SCAN.
- in_ready returns high the cycle after the out_last handshake. There is no same-cycle reload, so the minimum vector period is P+1 cycles.
- All-N-bits-set vector: N beats with indices N-1 down to 0; out_last is high on index 0 only.
- Single-bit vector: one beat, with out_last high on that beat.
- rst asserted mid-SCAN: `pend` is discarded and the block returns to IDLE immediately. No further beats for that vector.
- in_valid high during SCAN is ignored; the producer holds its vector until in_ready is high.

## Configuration
- SEQ_PENC_LSB_FIRST_EN:
  - Defined: lowest set index first. The all-ones N=16 vector yields 0,1,…,15.
  - Undefined (default): highest set index first, yielding 15,…,0.
- The macro affects only the priority direction; handshakes, out_last and zero_err are unchanged.

## Structure
- Package `seq_penc_pkg` holds:
  - the state typedef (IDLE, SCAN);
  - a default-width constant, 16;
  - the popcount-is-one helper function.
- Sub-module `pri_enc`: a combinational, N-parametrised priority encoder (vector → index plus any-set flag). Direction is selected by SEQ_PENC_LSB_FIRST_EN. The top level instantiates it once, on `pend`.
- The top level owns the FSM, `pend`, and the handshake and flag logic.

## Test plan
Benches use N=16.
- Reset mid-SCAN after 2 beats of 16'hF000 → all outputs at reset values. The next vector 16'h0001 yields a single beat, index 0, with out_last=1.
- 16'h8421 with out_ready=1 → indices 15,10,5,0 in consecutive cycles. out_last is high only on 0, and in_ready rises the next cycle.
- 16'h0000 accepted → zero_err=1 for exactly one cycle, no out_valid, in_ready stays 1.
- 16'h00C0 with out_ready low for 3 cycles → index 7 held stable throughout; then 7 followed by 6 with out_last.
- 16'hFFFF → 16 beats, 15 down to 0. With SEQ_PENC_LSB_FIRST_EN defined → 0 up to 15.
- in_valid held high with a second vector during SCAN → not captured until in_ready returns. Both vectors' index streams are complete and in order.
